// File: rtl/mem_arbiter_if.sv
// Request/grant/read-return bundle between one bus master and the memory arbiter.
// The master drives the command; the arbiter returns grant, read-valid and read data.
interface mem_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    localparam int unsigned MW = DW / 8;

    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [MW-1:0] wmask;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;

    modport master (
        output req, we, addr, wdata, wmask,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata, wmask,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master arbiter for the single CPU-side port of mem: bounded-burst rotation,
// zero-latency combinational grant, and one-cycle-late read data steering.
module mem_arbiter #(
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32
) (
    input  logic              clk,
    input  logic              reset,
    mem_arbiter_if.slave      m0,
    mem_arbiter_if.slave      m1,
    output logic [AW-1:0]     mem_addr,
    output logic              mem_we,
    output logic [DW-1:0]     mem_wdata,
    output logic [DW/8-1:0]   mem_wmask,
    input  logic [DW-1:0]     mem_rdata
);
    localparam int unsigned  CW      = 8;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } owner_e;

    owner_e        owner_q;
    logic          last_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]    rd_pend_q;

    logic          gnt0_c;
    logic          gnt1_c;
    logic          below_max_c;
    logic [CW-1:0] cnt_inc_c;

    assign below_max_c = (cnt_q < MAX_CNT);
    assign cnt_inc_c   = below_max_c ? (cnt_q + CW'(1)) : cnt_q;

    // Grant: owner keeps the port until its burst is spent and the other master waits.
    always_comb begin
        gnt0_c = 1'b0;
        gnt1_c = 1'b0;
        if (reset) begin
            case (owner_q)
                OWN0: begin
                    if (m0.req && (!m1.req || below_max_c)) begin
                        gnt0_c = 1'b1;
                    end else if (m1.req) begin
                        gnt1_c = 1'b1;
                    end
                end
                OWN1: begin
                    if (m1.req && (!m0.req || below_max_c)) begin
                        gnt1_c = 1'b1;
                    end else if (m0.req) begin
                        gnt0_c = 1'b1;
                    end
                end
                default: begin
                    gnt0_c = m0.req && (!m1.req || last_q);
                    gnt1_c = m1.req && !gnt0_c;
                end
            endcase
        end
    end

    // Ownership, burst count and pending-read tracking.
    always_ff @(posedge clk) begin
        if (!reset) begin
            owner_q   <= IDLE;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            rd_pend_q <= '0;
        end else begin
            rd_pend_q <= {gnt1_c & ~m1.we, gnt0_c & ~m0.we};
            if (gnt0_c) begin
                owner_q <= OWN0;
                last_q  <= 1'b0;
                cnt_q   <= (owner_q == OWN0) ? cnt_inc_c : CW'(1);
            end else if (gnt1_c) begin
                owner_q <= OWN1;
                last_q  <= 1'b1;
                cnt_q   <= (owner_q == OWN1) ? cnt_inc_c : CW'(1);
            end else begin
                owner_q <= IDLE;
                cnt_q   <= '0;
            end
        end
    end

    // Command mux defaults to master 0; the write strobe is gated by the grant.
    assign mem_addr  = gnt1_c ? m1.addr  : m0.addr;
    assign mem_wdata = gnt1_c ? m1.wdata : m0.wdata;
    assign mem_wmask = gnt1_c ? m1.wmask : m0.wmask;
    assign mem_we    = (gnt0_c & m0.we) | (gnt1_c & m1.we);

    assign m0.gnt    = gnt0_c;
    assign m1.gnt    = gnt1_c;
    assign m0.rvalid = rd_pend_q[0];
    assign m1.rvalid = rd_pend_q[1];
    assign m0.rdata  = mem_rdata;
    assign m1.rdata  = mem_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, single read, burst rotation, saturation
// with late arrival, write masking, and reset during a pending read.
module tb_mem_arbiter;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned MB = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [AW-1:0]   mem_addr;
    logic            mem_we;
    logic [DW-1:0]   mem_wdata;
    logic [DW/8-1:0] mem_wmask;
    logic [DW-1:0]   mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(AW), .DW(DW)) m0_if ();
    mem_arbiter_if #(.AW(AW), .DW(DW)) m1_if ();

    mem_arbiter #(.MAX_BURST(MB), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .m0        (m0_if),
        .m1        (m1_if),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .mem_rdata (mem_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Leaves the bench at a falling edge with reset released and the DUT freshly reset.
    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b0;
        m0_if.req = 1'b0;
        m1_if.req = 1'b0;
        @(negedge clk);
        reset     = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic g1;
        logic prev0;
        logic prev1;

        reset       = 1'b0;
        mem_rdata   = 32'hDEADBEEF;
        m0_if.req   = 1'b1;  m0_if.we = 1'b1;  m0_if.addr = 32'h100;
        m0_if.wdata = 32'h0; m0_if.wmask = 4'hF;
        m1_if.req   = 1'b1;  m1_if.we = 1'b0;  m1_if.addr = 32'h200;
        m1_if.wdata = 32'h0; m1_if.wmask = 4'hF;

        // Reset held with both masters requesting
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk($sformatf("t1_rst_gnt0_%0d", i), m0_if.gnt, 1'b0);
            chk($sformatf("t1_rst_gnt1_%0d", i), m1_if.gnt, 1'b0);
            chk($sformatf("t1_rst_we_%0d", i), mem_we, 1'b0);
            chk($sformatf("t1_rst_rv0_%0d", i), m0_if.rvalid, 1'b0);
            chk($sformatf("t1_rst_rv1_%0d", i), m1_if.rvalid, 1'b0);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("t1_rel_gnt0", m0_if.gnt, 1'b1);
        chk("t1_rel_gnt1", m1_if.gnt, 1'b0);
        chk("t1_rel_rv0", m0_if.rvalid, 1'b0);
        chk("t1_rel_rv1", m1_if.rvalid, 1'b0);

        // Single read by master 1
        do_reset();
        m1_if.req = 1'b1; m1_if.we = 1'b0; m1_if.addr = 32'h10;
        #1;
        chk("t2_gnt1", m1_if.gnt, 1'b1);
        chk("t2_gnt0", m0_if.gnt, 1'b0);
        chk("t2_addr", mem_addr, 32'h10);
        chk("t2_we", mem_we, 1'b0);
        @(negedge clk);
        m1_if.req = 1'b0;
        #1;
        chk("t2_rv1", m1_if.rvalid, 1'b1);
        chk("t2_rdata1", m1_if.rdata, 32'hDEADBEEF);
        chk("t2_rv0", m0_if.rvalid, 1'b0);
        chk("t2_gnt1_after", m1_if.gnt, 1'b0);

        // Burst rotation, both masters reading continuously
        do_reset();
        m0_if.req = 1'b1; m0_if.we = 1'b0; m0_if.addr = 32'h100;
        m1_if.req = 1'b1; m1_if.we = 1'b0; m1_if.addr = 32'h200;
        prev0 = 1'b0; prev1 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            g1 = ((i / 4) % 2) == 1;
            chk($sformatf("t3_gnt0_%0d", i), m0_if.gnt, !g1);
            chk($sformatf("t3_gnt1_%0d", i), m1_if.gnt, g1);
            chk($sformatf("t3_rv0_%0d", i), m0_if.rvalid, prev0);
            chk($sformatf("t3_rv1_%0d", i), m1_if.rvalid, prev1);
            prev0 = !g1;
            prev1 = g1;
        end

        // Master 0 alone saturates, master 1 arrives in cycle 6
        do_reset();
        m1_if.req = 1'b0; m1_if.we = 1'b0; m1_if.addr = 32'h200;
        m0_if.req = 1'b1; m0_if.we = 1'b1; m0_if.addr = 32'h100;
        for (int i = 1; i <= 10; i++) begin
            if (i > 1) @(negedge clk);
            if (i == 6) m1_if.req = 1'b1;
            #1;
            g1 = (i >= 6) && (i <= 9);
            chk($sformatf("t4_gnt0_%0d", i), m0_if.gnt, !g1);
            chk($sformatf("t4_gnt1_%0d", i), m1_if.gnt, g1);
            chk($sformatf("t4_addr_%0d", i), mem_addr, g1 ? 32'h200 : 32'h100);
        end

        // Masked write by master 0 interleaved with reads by master 1
        do_reset();
        m0_if.req = 1'b1; m0_if.we = 1'b1; m0_if.addr = 32'h40;
        m0_if.wdata = 32'h12345678; m0_if.wmask = 4'b0011;
        m1_if.req = 1'b1; m1_if.we = 1'b0; m1_if.addr = 32'h80;
        m1_if.wdata = 32'hCAFEF00D; m1_if.wmask = 4'hF;
        prev1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            g1 = ((i / 4) % 2) == 1;
            chk($sformatf("t5_we_%0d", i), mem_we, !g1);
            chk($sformatf("t5_wmask_%0d", i), mem_wmask, g1 ? 4'hF : 4'b0011);
            chk($sformatf("t5_wdata_%0d", i), mem_wdata, g1 ? 32'hCAFEF00D : 32'h12345678);
            chk($sformatf("t5_rv0_%0d", i), m0_if.rvalid, 1'b0);
            chk($sformatf("t5_rv1_%0d", i), m1_if.rvalid, prev1);
            prev1 = g1;
        end

        // Reset while a read by master 0 is outstanding
        do_reset();
        m1_if.req = 1'b0;
        m0_if.req = 1'b1; m0_if.we = 1'b0; m0_if.addr = 32'h44;
        #1;
        chk("t6_gnt0", m0_if.gnt, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("t6_rst_gnt0_a", m0_if.gnt, 1'b0);
        chk("t6_rst_we_a", mem_we, 1'b0);
        @(negedge clk); #1;
        chk("t6_rst_rv0", m0_if.rvalid, 1'b0);
        chk("t6_rst_gnt0_b", m0_if.gnt, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("t6_rel_rv0", m0_if.rvalid, 1'b0);
        chk("t6_rel_gnt0", m0_if.gnt, 1'b1);
        @(negedge clk);
        m0_if.req = 1'b0;
        #1;
        chk("t6_rel_rv0_late", m0_if.rvalid, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
